// File: rtl/sdfm_bus_arb.sv
// sdfm_bus_arb: two-requester arbiter and access sequencer for the SDFM
// register bus. Each granted request becomes one SETUP / ACCESS / DONE
// bus cycle with address setup, a strobe of HOLD_CYCLES cycles, and a
// one-cycle ack back to the requester that owned it.
//
// state  | meaning
// IDLE   | bus free; arbitrate and capture the winner on any req
// SETUP  | captured ADDR presented, gnt high, strobes low
// ACCESS | WR or RD high for HOLD_CYCLES cycles, read data sampled on last
// DONE   | strobes low, ADDR held, ack pulse, tie-break pointer updated
module sdfm_bus_arb #(
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic        EXTCLK,
   input  logic        EXTRSTn,
   input  logic [1:0]  req,
   input  logic [1:0]  req_we,
   input  logic [31:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic [1:0]  gnt,
   output logic [1:0]  ack,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        WR,
   output logic        RD,
   output logic [15:0] ADDR,
   inout  wire  [31:0] DATA
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_sel;
   logic        r_last;
   logic        r_we;
   logic        r_drive;
   logic [15:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [7:0]  r_cnt;
   logic [1:0]  r_gnt;
   logic [1:0]  r_ack;
   logic        r_busy;
   logic        r_wr;
   logic        r_rd;

   logic        w_sel;
   logic        w_we;
   logic [15:0] w_addr;
   logic [31:0] w_wdata;

   // Winner selection: lone requester wins, a tie goes to the one not served last.
   always_comb begin
      w_sel   = 1'b0;
      w_we    = 1'b0;
      w_addr  = 16'h0000;
      w_wdata = 32'h0000_0000;
      if (req == 2'b11) w_sel = ~r_last;
      else              w_sel = req[1];
      w_we    = req_we[w_sel];
      w_addr  = w_sel ? req_addr[31:16]  : req_addr[15:0];
      w_wdata = w_sel ? req_wdata[63:32] : req_wdata[31:0];
   end

   // Sequencer FSM with registered bus and handshake outputs.
   always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
      if (!EXTRSTn) begin
         r_state <= S_IDLE;
         r_sel   <= 1'b0;
         r_last  <= 1'b1;
         r_we    <= 1'b0;
         r_drive <= 1'b0;
         r_addr  <= 16'h0000;
         r_wdata <= 32'h0000_0000;
         r_rdata <= 32'h0000_0000;
         r_cnt   <= 8'h00;
         r_gnt   <= 2'b00;
         r_ack   <= 2'b00;
         r_busy  <= 1'b0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_sel   <= w_sel;
                  r_we    <= w_we;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_gnt   <= w_sel ? 2'b10 : 2'b01;
                  r_busy  <= 1'b1;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_cnt   <= 8'(HOLD_CYCLES - 1);
               r_wr    <= r_we;
               r_rd    <= ~r_we;
               r_drive <= r_we;
               r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (r_cnt == 8'h00) begin
                  r_wr    <= 1'b0;
                  r_rd    <= 1'b0;
                  r_drive <= 1'b0;
                  if (!r_we) r_rdata <= DATA;
                  r_ack   <= r_sel ? 2'b10 : 2'b01;
                  r_last  <= r_sel;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 8'h01;
               end
            end
            S_DONE: begin
               r_ack   <= 2'b00;
               r_gnt   <= 2'b00;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The data bus is only driven while a write strobe is up.
   assign DATA  = r_drive ? r_wdata : {32{1'bz}};
   assign gnt   = r_gnt;
   assign ack   = r_ack;
   assign rdata = r_rdata;
   assign busy  = r_busy;
   assign WR    = r_wr;
   assign RD    = r_rd;
   assign ADDR  = r_addr;

endmodule

// File: tb/tb_sdfm_bus_arb.sv
// Testbench for sdfm_bus_arb: transaction-level timestamp model feeding an
// expected-transaction queue, a monitor popping it on every ack, plus
// directed scenarios and two extra instances for HOLD_CYCLES 1 and 255.
module tb_sdfm_bus_arb;

   localparam int H = 2;

   logic        EXTCLK;
   logic        EXTRSTn;
   logic [1:0]  req;
   logic [1:0]  req_we;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  gnt;
   logic [1:0]  ack;
   logic [31:0] rdata;
   logic        busy;
   logic        WR;
   logic        RD;
   logic [15:0] ADDR;
   wire  [31:0] DATA;

   typedef struct {
      logic        sel;
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          t0;
   } txn_t;

   txn_t        exp_q[$];
   int          sel_log[$];
   txn_t        cur;
   txn_t        nt;
   txn_t        popped;
   int          free_at;
   int          rel;
   logic        m_last;
   logic [31:0] mon_rdata;
   logic        exp_wr;
   logic        exp_rd;
   logic [31:0] exp_data;
   int          cyc;
   int          checks;
   int          errors;
   bit          auto_drop;

   // register map stand-in: answers reads, otherwise holds the bus at zero
   function automatic logic [31:0] mem_rd(input logic [15:0] a);
      if (a == 16'h0724) return 32'hDEAD_BEEF;
      return {a ^ 16'h5A3C, ~a};
   endfunction

   assign DATA = WR ? {32{1'bz}} : (RD ? mem_rd(ADDR) : 32'h0000_0000);

   sdfm_bus_arb #(.HOLD_CYCLES(H)) dut (
      .EXTCLK(EXTCLK), .EXTRSTn(EXTRSTn), .req(req), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
      .rdata(rdata), .busy(busy), .WR(WR), .RD(RD), .ADDR(ADDR), .DATA(DATA)
   );

   // extra instances for the HOLD_CYCLES extremes
   logic [1:0]  a_req   [2];
   logic [1:0]  a_we    [2];
   logic [31:0] a_addr  [2];
   logic [63:0] a_wd    [2];
   logic [1:0]  a_gnt   [2];
   logic [1:0]  a_ack   [2];
   logic [31:0] a_rdata [2];
   logic        a_busy  [2];
   logic        a_wr    [2];
   logic        a_rd    [2];
   logic [15:0] a_adr   [2];
   wire  [31:0] a_data0;
   wire  [31:0] a_data1;

   assign a_data0 = a_rd[0] ? 32'hC0DE_0001 : (a_wr[0] ? {32{1'bz}} : 32'h0);
   assign a_data1 = a_rd[1] ? 32'hC0DE_0002 : (a_wr[1] ? {32{1'bz}} : 32'h0);

   sdfm_bus_arb #(.HOLD_CYCLES(1)) u_h1 (
      .EXTCLK(EXTCLK), .EXTRSTn(EXTRSTn), .req(a_req[0]), .req_we(a_we[0]),
      .req_addr(a_addr[0]), .req_wdata(a_wd[0]), .gnt(a_gnt[0]), .ack(a_ack[0]),
      .rdata(a_rdata[0]), .busy(a_busy[0]), .WR(a_wr[0]), .RD(a_rd[0]),
      .ADDR(a_adr[0]), .DATA(a_data0)
   );

   sdfm_bus_arb #(.HOLD_CYCLES(255)) u_h255 (
      .EXTCLK(EXTCLK), .EXTRSTn(EXTRSTn), .req(a_req[1]), .req_we(a_we[1]),
      .req_addr(a_addr[1]), .req_wdata(a_wd[1]), .gnt(a_gnt[1]), .ack(a_ack[1]),
      .rdata(a_rdata[1]), .busy(a_busy[1]), .WR(a_wr[1]), .RD(a_rd[1]),
      .ADDR(a_adr[1]), .DATA(a_data1)
   );

   initial EXTCLK = 1'b0;
   always #5 EXTCLK = ~EXTCLK;

   always @(posedge EXTCLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: bus free from free_at on; an access started at cycle t0
   // owns cycles t0+1 .. t0+2+H with strobe on t0+2 .. t0+1+H and ack on t0+2+H.
   always @(negedge EXTCLK) begin
      if (!EXTRSTn) begin
         exp_q.delete();
         free_at = 0;
         m_last  = 1'b1;
         chk("rst_wr", WR, 0);
         chk("rst_rd", RD, 0);
         chk("rst_gnt", gnt, 0);
         chk("rst_ack", ack, 0);
         chk("rst_busy", busy, 0);
         chk("rst_addr", ADDR, 0);
         chk("rst_rdata", rdata, 0);
         chk("rst_data", DATA, 0);
      end else if (cyc >= free_at) begin
         chk("idle_gnt", gnt, 0);
         chk("idle_busy", busy, 0);
         chk("idle_wr", WR, 0);
         chk("idle_rd", RD, 0);
         chk("idle_ack", ack, 0);
         chk("idle_data", DATA, 0);
         if (req != 2'b00) begin
            nt.sel   = (req == 2'b11) ? ~m_last : req[1];
            nt.we    = req_we[nt.sel];
            nt.addr  = req_addr[nt.sel*16 +: 16];
            nt.wdata = req_wdata[nt.sel*32 +: 32];
            nt.t0    = cyc;
            exp_q.push_back(nt);
            cur     = nt;
            free_at = cyc + H + 3;
            m_last  = nt.sel;
         end
      end else begin
         rel    = cyc - cur.t0;
         exp_wr = cur.we && rel >= 2 && rel <= H + 1;
         exp_rd = !cur.we && rel >= 2 && rel <= H + 1;
         if (exp_wr)      exp_data = cur.wdata;
         else if (exp_rd) exp_data = mem_rd(cur.addr);
         else             exp_data = 32'h0;
         chk("gnt", gnt, cur.sel ? 2'b10 : 2'b01);
         chk("busy", busy, 1);
         chk("addr", ADDR, cur.addr);
         chk("wr", WR, exp_wr);
         chk("rd", RD, exp_rd);
         chk("data", DATA, exp_data);
         if (rel != H + 2) chk("ack_early", ack, 0);
      end
   end

   // Monitor: every ack consumes the oldest expected transaction.
   always @(negedge EXTCLK) begin
      if (!EXTRSTn) begin
         mon_rdata = 32'h0;
      end else if (ack != 2'b00) begin
         if (exp_q.size() == 0) begin
            chk("ack_unexpected", ack, 0);
         end else begin
            popped = exp_q.pop_front();
            if (!popped.we) mon_rdata = mem_rd(popped.addr);
            chk("ack_sel", ack, popped.sel ? 2'b10 : 2'b01);
            chk("ack_time", cyc, popped.t0 + 2 + H);
            chk("ack_rdata", rdata, mon_rdata);
            sel_log.push_back(int'(popped.sel));
         end
      end
   end

   task automatic tick();
      @(posedge EXTCLK);
      #1;
      if (auto_drop) begin
         if (ack[0]) req[0] = 1'b0;
         if (ack[1]) req[1] = 1'b0;
      end
   endtask

   task automatic issue(input int i, input logic we, input logic [15:0] a, input logic [31:0] wd);
      req_we[i]           = we;
      req_addr[i*16 +: 16] = a;
      req_wdata[i*32 +: 32] = wd;
      req[i]              = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((req != 2'b00 || busy) && n < 400) begin
         tick();
         n++;
      end
      chk("wait_idle_timeout", (n < 400), 1);
   endtask

   task automatic aux_run(input int k, input int hk, input logic we, input logic [15:0] a);
      int n, wr_n, rd_n, lat;
      a_we[k]   = {1'b0, we};
      a_addr[k] = {16'h0000, a};
      a_wd[k]   = {32'h0, 32'hA5A5_0000 | {16'h0, a}};
      a_req[k]  = 2'b01;
      n = 0; wr_n = 0; rd_n = 0; lat = -1;
      while (lat < 0 && n < hk + 20) begin
         @(posedge EXTCLK);
         #1;
         n++;
         if (a_wr[k]) wr_n++;
         if (a_rd[k]) rd_n++;
         if (a_ack[k][0]) begin
            lat = n;
            a_req[k] = 2'b00;
            if (!we) chk("aux_rdata", a_rdata[k], (k == 0) ? 32'hC0DE_0001 : 32'hC0DE_0002);
         end
      end
      a_req[k] = 2'b00;
      chk("aux_ack_latency", lat, hk + 2);
      chk("aux_wr_width", wr_n, we ? hk : 0);
      chk("aux_rd_width", rd_n, we ? 0 : hk);
      repeat (2) tick();
      chk("aux_busy_after", a_busy[k], 0);
      chk("aux_gnt_after", a_gnt[k], 0);
   endtask

   initial begin
      int ls;
      checks = 0; errors = 0; auto_drop = 1'b1;
      req = 2'b00; req_we = 2'b00; req_addr = 32'h0; req_wdata = 64'h0;
      for (int k = 0; k < 2; k++) begin
         a_req[k] = 2'b00; a_we[k] = 2'b00; a_addr[k] = 32'h0; a_wd[k] = 64'h0;
      end
      EXTRSTn = 1'b0;
      repeat (3) @(posedge EXTCLK);
      #3 EXTRSTn = 1'b1;

      // contention straight out of reset: requester 0 wins first, then strict alternation
      tick();
      auto_drop = 1'b0;
      ls = sel_log.size();
      issue(0, 1'b1, 16'h0100, 32'h1111_0000);
      issue(1, 1'b0, 16'h0200, 32'h0);
      repeat (4 * (H + 3) + 1) tick();
      req = 2'b00;
      auto_drop = 1'b1;
      wait_idle();
      chk("contend_count_ok", (sel_log.size() >= ls + 4), 1);
      if (sel_log.size() >= ls + 4) begin
         chk("contend_order0", sel_log[ls],     0);
         chk("contend_order1", sel_log[ls + 1], 1);
         chk("contend_order2", sel_log[ls + 2], 0);
         chk("contend_order3", sel_log[ls + 3], 1);
      end

      // single write, then single read that returns 0xDEADBEEF
      issue(0, 1'b1, 16'h070C, 32'h0012_3408);
      wait_idle();
      issue(1, 1'b0, 16'h0724, 32'hFFFF_FFFF);
      wait_idle();
      chk("read_deadbeef", rdata, 32'hDEAD_BEEF);
      issue(0, 1'b1, 16'h0010, 32'h5555_AAAA);
      wait_idle();
      chk("rdata_held_over_write", rdata, 32'hDEAD_BEEF);

      // short req1 pulse while requester 0 owns the bus is never granted
      issue(0, 1'b0, 16'h0030, 32'h0);
      tick(); tick();
      issue(1, 1'b1, 16'h0040, 32'h4040_4040);
      tick();
      req[1] = 1'b0;
      wait_idle();

      // req0 dropped during ACCESS still completes with an ack
      issue(0, 1'b1, 16'h0050, 32'h5050_5050);
      tick(); tick();
      req[0] = 1'b0;
      wait_idle();

      // reset in the second write ACCESS cycle
      issue(0, 1'b1, 16'h0060, 32'h6060_6060);
      tick(); tick(); tick();
      chk("pre_reset_wr", WR, 1);
      #2 EXTRSTn = 1'b0;
      #1;
      chk("async_rst_wr", WR, 0);
      chk("async_rst_gnt", gnt, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_ack", ack, 0);
      chk("async_rst_data", DATA, 0);
      req = 2'b00;
      repeat (2) @(posedge EXTCLK);
      #3 EXTRSTn = 1'b1;
      repeat (6) tick();

      // randomized traffic with withdrawals and post-capture input changes
      for (int cy = 0; cy < 600; cy++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 3) == 0)
                  issue(i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
            end else if (!gnt[i]) begin
               if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
               req_we[i]             = ~req_we[i];
               req_addr[i*16 +: 16]  = 16'($urandom);
               req_wdata[i*32 +: 32] = $urandom;
            end
         end
      end
      wait_idle();
      repeat (3) tick();
      chk("queue_drained", exp_q.size(), 0);

      // HOLD_CYCLES extremes
      aux_run(0, 1, 1'b1, 16'h0101);
      aux_run(0, 1, 1'b0, 16'h0102);
      aux_run(1, 255, 1'b1, 16'h0201);
      aux_run(1, 255, 1'b0, 16'h0202);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
